// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous pulse input over back-to-back
// windows of GATE_CYCLES clocks and publishes each count with a one-cycle strobe.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned WIDTH       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_sig_in,
    output logic [WIDTH-1:0] o_freq,
    output logic             o_freq_valid,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam int unsigned      GateW    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CntMax   = '1;

    typedef enum logic [0:0] {
        StIdle,
        StMeasure
    } state_e;

    state_e             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [GateW-1:0]   r_gate_cnt;
    logic [WIDTH-1:0]   r_edge_cnt;
    logic               r_sat;
    logic [WIDTH-1:0]   r_freq;
    logic               r_freq_valid;
    logic               r_overflow;
    logic               r_busy;

    logic               w_edge;
    logic               w_cnt_full;
    logic [WIDTH-1:0]   w_next_cnt;
    logic               w_next_sat;

    // Two flops resolve metastability; the third only remembers the previous level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge     = r_sync2 & ~r_sync3;
    assign w_cnt_full = (r_edge_cnt == CntMax);
    // sat marks a window in which at least one edge was dropped at full scale.
    assign w_next_cnt = (w_edge && !w_cnt_full) ? r_edge_cnt + WIDTH'(1) : r_edge_cnt;
    assign w_next_sat = r_sat | (w_edge & w_cnt_full);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_busy <= 1'b0;
                    if (i_enable) begin
                        r_state    <= StMeasure;
                        r_busy     <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end
                end
                StMeasure: begin
                    if (!i_enable) begin
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else if (r_gate_cnt == GateLast) begin
                        // Final cycle's edge is folded in; next window starts with no gap.
                        r_freq       <= w_next_cnt;
                        r_overflow   <= w_next_sat;
                        r_freq_valid <= 1'b1;
                        r_gate_cnt   <= '0;
                        r_edge_cnt   <= '0;
                        r_sat        <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GateW'(1);
                        r_edge_cnt <= w_next_cnt;
                        r_sat      <= w_next_sat;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_freq       = r_freq;
    assign o_freq_valid = r_freq_valid;
    assign o_overflow   = r_overflow;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: two widths share one stimulus and are checked
// every cycle against an edge-arrival / window-count reference model.
module tb_freq_meter;

    localparam int unsigned Gate = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sig_in;
    logic [7:0] freq8;
    logic       valid8, ovf8, busy8;
    logic [3:0] freq4;
    logic       valid4, ovf4, busy4;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(Gate), .WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sig_in(sig_in),
        .o_freq(freq8), .o_freq_valid(valid8), .o_overflow(ovf8), .o_busy(busy8)
    );

    freq_meter #(.GATE_CYCLES(Gate), .WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sig_in(sig_in),
        .o_freq(freq4), .o_freq_valid(valid4), .o_overflow(ovf4), .o_busy(busy4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int arr_q[$];
    bit sig_prev, en_d, sig_d;
    int w_per = 0;
    int w_ph  = 0;
    bit m_run, m_valid;
    int m_pos, m_cnt, m_last;
    int win_lo = -1;
    int win_hi = -1;
    int win_edges = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_run = 0; m_valid = 0; m_pos = 0; m_cnt = 0; m_last = 0;
        arr_q.delete();
    endtask

    // Edges arrive 3 posedges after the drive slot; windows count posedges 1..Gate.
    task automatic model_step();
        bit hit;
        hit = 0;
        while (arr_q.size() > 0 && arr_q[0] <= cyc) begin
            if (arr_q[0] == cyc) hit = 1;
            void'(arr_q.pop_front());
        end
        m_valid = 0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1; m_pos = 0; m_cnt = 0;
            end
        end else if (!enable) begin
            m_run = 0;
        end else begin
            m_cnt += int'(hit);
            m_pos++;
            if (m_pos == Gate) begin
                m_last = m_cnt; m_valid = 1; m_pos = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("freq8", 32'(freq8), 32'(min_int(m_last, 255)));
        check_val("ovf8", 32'(ovf8), (m_last > 255) ? 32'd1 : 32'd0);
        check_val("valid8", 32'(valid8), 32'(m_valid));
        check_val("busy8", 32'(busy8), 32'(m_run));
        check_val("freq4", 32'(freq4), 32'(min_int(m_last, 15)));
        check_val("ovf4", 32'(ovf4), (m_last > 15) ? 32'd1 : 32'd0);
        check_val("valid4", 32'(valid4), 32'(m_valid));
        check_val("busy4", 32'(busy4), 32'(m_run));
    endtask

    // w_per > 0: square wave; w_per < 0: random bit per cycle; 0: hold sig_d.
    task automatic tick();
        if (w_per > 0) begin
            sig_d = (w_ph < w_per / 2);
            w_ph  = (w_ph + 1) % w_per;
        end else if (w_per < 0) begin
            sig_d = 1'($urandom_range(0, 1));
        end
        if (sig_d && !sig_prev) begin
            arr_q.push_back(cyc + 3);
            if (cyc + 3 >= win_lo && cyc + 3 <= win_hi) win_edges++;
        end
        sig_prev = sig_d;
        sig_in   = sig_d;
        enable   = en_d;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_freq8", 32'(freq8), 0);
        check_val("rst_ovf8", 32'(ovf8), 0);
        check_val("rst_valid8", 32'(valid8), 0);
        check_val("rst_busy8", 32'(busy8), 0);
        check_val("rst_freq4", 32'(freq4), 0);
        check_val("rst_busy4", 32'(busy4), 0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n    = 1'b1;
        sig_prev = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (valid8) begin
                ok = 1;
                break;
            end
        end
        check_val("valid_seen", 32'(ok), 1);
    endtask

    task automatic wait_pos(input int target, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (m_run && m_pos == target) begin
                ok = 1;
                break;
            end
        end
        check_val("pos_reached", 32'(ok), 1);
    endtask

    initial begin
        int lat;
        int sum;
        rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
        en_d = 0; sig_d = 0; sig_prev = 0;
        model_reset();
        do_reset();

        // Steady 10-clock period.
        en_d = 1; w_per = 10; w_ph = 0;
        repeat (350) tick();
        wait_valid(150);
        check_val("p10_freq", 32'(freq8), 10);
        check_val("p10_busy", 32'(busy8), 1);

        // 2-clock period saturates the narrow counter only.
        w_per = 2; w_ph = 0;
        repeat (250) tick();
        wait_valid(150);
        check_val("p2_freq8", 32'(freq8), 50);
        check_val("p2_freq4", 32'(freq4), 15);
        check_val("p2_ovf4", 32'(ovf4), 1);
        w_per = 10; w_ph = 0;
        wait_valid(150);
        wait_valid(150);
        check_val("p10_freq4", 32'(freq4), 10);
        check_val("p10_ovf4", 32'(ovf4), 0);

        // Abort mid-window, then re-enable.
        wait_pos(50, 150);
        en_d = 0;
        tick();
        check_val("abort_busy", 32'(busy8), 0);
        repeat (20) tick();
        check_val("abort_hold", 32'(freq8), 10);
        en_d = 1;
        lat = 0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (valid8) begin
                lat = i;
                break;
            end
        end
        check_val("reenter_lat", 32'(lat), 101);

        // Single edge landing on the final gate cycle.
        w_per = 0; sig_d = 0;
        repeat (110) tick();
        wait_pos(Gate - 3, 150);
        sig_d = 1; tick();
        sig_d = 0; tick();
        wait_valid(150);
        check_val("last_cycle_edge", 32'(freq8), 1);
        wait_valid(150);
        check_val("after_last_edge", 32'(freq8), 0);

        // Ten back-to-back windows of period 7: no edge lost or double counted.
        en_d = 0;
        repeat (3) tick();
        en_d = 1;
        win_lo = cyc + 2; win_hi = cyc + 1 + 10 * Gate; win_edges = 0;
        w_per = 7; w_ph = 0;
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            wait_valid(150);
            sum += int'(freq8);
        end
        check_val("sum10", 32'(sum), 32'(win_edges));
        win_lo = -1; win_hi = -1;

        // Reset mid-window.
        w_per = 10; w_ph = 0;
        wait_valid(150);
        wait_valid(150);
        check_val("pre_rst_freq", 32'(freq8), 10);
        repeat (40) tick();
        do_reset();
        repeat (250) tick();

        // Input held high across reset release.
        w_per = 0; sig_d = 1; sig_in = 1'b1;
        do_reset();
        wait_valid(150);
        check_val("const_first", (freq8 <= 8'd1) ? 32'd1 : 32'd0, 1);
        wait_valid(150);
        check_val("const_next", 32'(freq8), 0);

        // Randomized segments.
        for (int s = 0; s < 8; s++) begin
            int n;
            if ($urandom_range(0, 2) == 0) do_reset();
            w_per = (s == 3 || s == 6) ? -1 : int'($urandom_range(2, 20));
            w_ph  = int'($urandom_range(0, 1));
            n     = int'($urandom_range(200, 600));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 199) == 0) en_d = !en_d;
                tick();
            end
            en_d = 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
